gatefn_share_sched: RTL and testbench

GATEFN_SHARE_SCHED -- requirements
Module: gatefn_share_sched

---
 rtl/gatefn_share_sched_pkg.sv | 27 ++
 rtl/gatefn_share_sched_pergate.sv | 38 +++
 rtl/gatefn_share_sched.sv | 95 +++++++++
 tb/tb_gatefn_share_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gatefn_share_sched_pkg.sv
// gatefn_sched_pkg: field constants, FSM states and mod-p helpers for the shared gate-function scheduler.
package gatefn_sched_pkg;
   localparam int F_NBITS = 16;
   localparam int GATEFN_BITS = 1;
   localparam logic [F_NBITS-1:0] F_PRIME = 16'd65521;
   localparam logic [GATEFN_BITS-1:0] GATEFN_ADD = 1'b0;
   localparam logic [GATEFN_BITS-1:0] GATEFN_MUL = 1'b1;
   localparam int NREQ_DEF = 4;
   localparam int IDX_W = $clog2(NREQ_DEF);
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;
   typedef logic [F_NBITS-1:0] fe_t;
   function automatic fe_t f_add(input fe_t a, input fe_t b);
      logic [F_NBITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= {1'b0, F_PRIME}) ? fe_t'(s - {1'b0, F_PRIME}) : fe_t'(s);
   endfunction
   // 2^16 == 15 (mod F_PRIME): fold the high half back in twice, then one conditional subtract
   function automatic fe_t f_mul(input fe_t a, input fe_t b);
      logic [2*F_NBITS-1:0] p;
      logic [20:0] t;
      logic [16:0] u;
      p = {16'd0, a} * {16'd0, b};
      t = 21'(p[31:16]) * 21'd15 + 21'(p[15:0]);
      u = 17'(t[20:16]) * 17'd15 + 17'(t[15:0]);
      return (u >= {1'b0, F_PRIME}) ? fe_t'(u - {1'b0, F_PRIME}) : fe_t'(u);
   endfunction
endpackage

// File: rtl/gatefn_share_sched_pergate.sv
// pergate_compute_gatefn_seq: three-lane field add/mul unit; results and ready register one cycle after en.
module pergate_compute_gatefn_seq
   import gatefn_sched_pkg::*;
#(
   parameter logic [GATEFN_BITS-1:0] gate_fn = GATEFN_ADD
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    en,
   input  logic                    mux_sel,
   input  logic [2:0][F_NBITS-1:0] in0,
   input  logic [2:0][F_NBITS-1:0] in1,
   output logic                    ready,
   output logic [2:0][F_NBITS-1:0] gatefn
);
   logic [2:0][F_NBITS-1:0] res_q, res_d;
   logic ready_q, ready_d;
   // mux_sel bypasses the arithmetic and forwards the first operand
   always_comb begin
      ready_d = en;
      res_d = res_q;
      for (int k = 0; k < 3; k++)
         res_d[k] = !en ? res_q[k] :
                    mux_sel ? in0[k] :
                    (gate_fn == GATEFN_MUL) ? f_mul(in0[k], in1[k]) : f_add(in0[k], in1[k]);
   end
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         res_q <= '0;
         ready_q <= 1'b0;
      end else begin
         res_q <= res_d;
         ready_q <= ready_d;
      end
   end
   assign ready = ready_q;
   assign gatefn = res_q;
endmodule

// File: rtl/gatefn_share_sched.sv
// gatefn_share_sched: round-robin arbiter time-sharing one gate-function unit among NREQ requesters.
module gatefn_share_sched
   import gatefn_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter logic [GATEFN_BITS-1:0] gate_fn = GATEFN_ADD
) (
   input  logic                              clk,
   input  logic                              rstb,
   input  logic [NREQ-1:0]                   req,
   input  logic                              mux_sel,
   input  logic [NREQ-1:0][2:0][F_NBITS-1:0] in0,
   input  logic [NREQ-1:0][2:0][F_NBITS-1:0] in1,
   output logic [NREQ-1:0]                   done,
   output logic [NREQ-1:0][2:0][F_NBITS-1:0] gatefn,
   output logic [NREQ-1:0]                   pending,
   output logic                              idle
);
   localparam int IW = $clog2(NREQ);
   localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
   state_t state_q, state_d;
   logic [IW-1:0] grant_q, grant_d, rr_q, rr_d;
   logic [NREQ-1:0] pending_q, pending_d, done_q, done_d, clr;
   logic [NREQ-1:0][2:0][F_NBITS-1:0] gatefn_q, gatefn_d;
   logic unit_en, unit_ready, complete;
   logic [2:0][F_NBITS-1:0] unit_res;
   // descending scan so the smallest cyclic offset from ptr is the last (winning) assignment
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] p, input logic [IW-1:0] ptr);
      logic [IW-1:0] g;
      int j;
      g = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NREQ;
         g = p[j] ? IW'(j) : g;
      end
      return g;
   endfunction
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_q <= ST_IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = |pending_q ? ST_START : ST_IDLE;
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  state_d = unit_ready ? ST_IDLE : ST_WAIT;
         default:  state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      unit_en = state_q == ST_START;
      complete = (state_q == ST_WAIT) && unit_ready;
   end
   // a req landing on the completing cycle re-arms pending after the clear
   always_comb begin
      grant_d = (state_q == ST_IDLE && |pending_q) ? rr_pick(pending_q, rr_q) : grant_q;
      rr_d = complete ? ((grant_q == LAST) ? '0 : grant_q + 1'b1) : rr_q;
      clr = complete ? (NREQ'(1) << grant_q) : '0;
      done_d = clr;
      pending_d = (pending_q & ~clr) | req;
      gatefn_d = gatefn_q;
      for (int i = 0; i < NREQ; i++)
         gatefn_d[i] = clr[i] ? unit_res : gatefn_q[i];
   end
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         grant_q <= '0;
         rr_q <= '0;
         pending_q <= '0;
         done_q <= '0;
         gatefn_q <= '0;
      end else begin
         grant_q <= grant_d;
         rr_q <= rr_d;
         pending_q <= pending_d;
         done_q <= done_d;
         gatefn_q <= gatefn_d;
      end
   end
   pergate_compute_gatefn_seq #(.gate_fn(gate_fn)) u_unit (
      .clk(clk),
      .rstb(rstb),
      .en(unit_en),
      .mux_sel(mux_sel),
      .in0(in0[grant_q]),
      .in1(in1[grant_q]),
      .ready(unit_ready),
      .gatefn(unit_res)
   );
   assign done = done_q;
   assign gatefn = gatefn_q;
   assign pending = pending_q;
   assign idle = (state_q == ST_IDLE) && !(|pending_q);
endmodule

// File: tb/tb_gatefn_share_sched.sv
// tb_gatefn_share_sched: add and mul instances driven in lockstep, checked against field arithmetic and round-robin rules.
module tb_gatefn_share_sched;
   localparam int N = 4;
   localparam longint P = 65521;
   typedef logic [2:0][15:0] tri_t;
   typedef struct {
      int   idx;
      tri_t a;
      tri_t b;
      tri_t add_r;
      tri_t mul_r;
   } vec_t;
   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic mux_sel = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0][2:0][15:0] in0 = '0, in1 = '0, gf_a, gf_m;
   logic [N-1:0] done_a, done_m, pend_a, pend_m;
   logic idle_a, idle_m;
   int total = 0, bad = 0;
   tri_t expw_a [N];
   tri_t expw_m [N];
   logic [N-1:0] outst;
   int waitc [N];
   vec_t tv [4];

   always #5 clk = ~clk;

   gatefn_share_sched #(.NREQ(N), .gate_fn(1'b0)) u_add (
      .clk(clk), .rstb(rstb), .req(req), .mux_sel(mux_sel), .in0(in0), .in1(in1),
      .done(done_a), .gatefn(gf_a), .pending(pend_a), .idle(idle_a));
   gatefn_share_sched #(.NREQ(N), .gate_fn(1'b1)) u_mul (
      .clk(clk), .rstb(rstb), .req(req), .mux_sel(mux_sel), .in0(in0), .in1(in1),
      .done(done_m), .gatefn(gf_m), .pending(pend_m), .idle(idle_m));

   function automatic tri_t tri3(input int v0, input int v1, input int v2);
      tri_t r;
      r[0] = 16'(v0);
      r[1] = 16'(v1);
      r[2] = 16'(v2);
      return r;
   endfunction

   function automatic tri_t ref_fn(input bit mul, input bit byp, input tri_t a, input tri_t b);
      tri_t r;
      longint x, y;
      for (int k = 0; k < 3; k++) begin
         x = longint'(a[k]);
         y = longint'(b[k]);
         r[k] = byp ? a[k] : 16'(mul ? (x * y) % P : (x + y) % P);
      end
      return r;
   endfunction

   function automatic logic [15:0] rv();
      return ($urandom_range(0, 3) == 0) ? 16'(P - 1) : 16'($urandom_range(0, 32'(P - 1)));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_words(input string nm);
      for (int j = 0; j < N; j++) begin
         chk($sformatf("%s_add_w%0d", nm, j), 64'(gf_a[j]), 64'(expw_a[j]));
         chk($sformatf("%s_mul_w%0d", nm, j), 64'(gf_m[j]), 64'(expw_m[j]));
      end
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      req = '1;
      repeat (2) @(negedge clk);
      chk("rst_pending", {60'd0, pend_a | pend_m}, 64'd0);
      rstb = 1'b1;
      req = '0;
      @(negedge clk);
      for (int j = 0; j < N; j++) begin
         expw_a[j] = '0;
         expw_m[j] = '0;
      end
      chk("rst_done", {60'd0, done_a | done_m}, 64'd0);
      chk("rst_idle", {62'd0, idle_a, idle_m}, 64'd3);
      chk_words("rst");
   endtask

   task automatic wait_done(input int limit, output int cyc, output logic [N-1:0] d);
      cyc = 0;
      d = '0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         req = '0;
         if (done_a != 0 || done_m != 0) begin
            cyc = c;
            d = done_a;
            break;
         end
      end
      chk("done_agree", {60'd0, done_a}, {60'd0, done_m});
   endtask

   task automatic model_step();
      logic [N-1:0] d;
      tri_t ea, em;
      d = done_a;
      if (done_a != 0 || done_m != 0) begin
         chk("rand_onehot", {63'd0, $onehot(done_a)}, 64'd1);
         chk("rand_done_agree", {60'd0, done_a}, {60'd0, done_m});
         for (int i = 0; i < N; i++) begin
            if (d[i]) begin
               ea = ref_fn(1'b0, mux_sel, in0[i], in1[i]);
               em = ref_fn(1'b1, mux_sel, in0[i], in1[i]);
               chk($sformatf("rand_outst%0d", i), {63'd0, outst[i]}, 64'd1);
               chk($sformatf("rand_wait%0d", i), {63'd0, waitc[i] <= N - 1}, 64'd1);
               chk($sformatf("rand_add%0d", i), 64'(gf_a[i]), 64'(ea));
               chk($sformatf("rand_mul%0d", i), 64'(gf_m[i]), 64'(em));
               outst[i] = 1'b0;
               for (int j = 0; j < N; j++)
                  if (j != i && outst[j]) waitc[j]++;
            end
         end
      end
      for (int i = 0; i < N; i++)
         if (req[i] && !outst[i]) begin
            outst[i] = 1'b1;
            waitc[i] = 0;
         end
      chk("rand_pending", {56'd0, pend_a, pend_m}, {56'd0, outst, outst});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic [N-1:0] d;
      int cnt;
      int seq [4];
      tv[0] = '{2, tri3(2, 3, 4), tri3(5, 6, 7), tri3(7, 9, 11), tri3(10, 18, 28)};
      tv[1] = '{0, tri3(65520, 65520, 1), tri3(1, 65520, 0), tri3(0, 65519, 1), tri3(65520, 1, 0)};
      tv[2] = '{3, tri3(256, 1000, 40000), tri3(256, 1000, 2), tri3(512, 2000, 40002), tri3(15, 17185, 14479)};
      tv[3] = '{1, tri3(0, 12345, 65000), tri3(9, 0, 1000), tri3(9, 12345, 479), tri3(0, 0, 3168)};

      do_reset();

      // single jobs from idle: latency, one-hot done, target word updated, others held
      for (int v = 0; v < 4; v++) begin
         in0[tv[v].idx] = tv[v].a;
         in1[tv[v].idx] = tv[v].b;
         req = 4'(1) << tv[v].idx;
         wait_done(20, cyc, d);
         chk($sformatf("vec%0d_latency", v), 64'(cyc), 64'd4);
         chk($sformatf("vec%0d_done", v), {60'd0, d}, {60'd0, 4'(1) << tv[v].idx});
         expw_a[tv[v].idx] = tv[v].add_r;
         expw_m[tv[v].idx] = tv[v].mul_r;
         chk_words($sformatf("vec%0d", v));
         @(negedge clk);
         chk($sformatf("vec%0d_pulse", v), {60'd0, done_a | done_m}, 64'd0);
         chk($sformatf("vec%0d_idle", v), {62'd0, idle_a, idle_m}, 64'd3);
      end

      // all four at once: order 0..3, back-to-back spacing
      do_reset();
      for (int i = 0; i < N; i++) begin
         in0[i] = tri3(i, i, i);
         in1[i] = tri3(1, 1, 1);
      end
      req = '1;
      for (int n = 0; n < N; n++) begin
         wait_done(20, cyc, d);
         chk($sformatf("all_order%0d", n), {60'd0, d}, {60'd0, 4'(1) << n});
         chk($sformatf("all_gap%0d", n), 64'(cyc), (n == 0) ? 64'd4 : 64'd3);
         expw_a[n] = tri3(n + 1, n + 1, n + 1);
         expw_m[n] = tri3(n, n, n);
      end
      chk_words("all");

      // pointer after serving 1 is 2, so 0 wins over 1
      req = 4'b0010;
      wait_done(20, cyc, d);
      chk("rr_first", {60'd0, d}, 64'h2);
      req = 4'b0011;
      wait_done(20, cyc, d);
      chk("rr_a", {60'd0, d}, 64'h1);
      wait_done(20, cyc, d);
      chk("rr_b", {60'd0, d}, 64'h2);

      // re-request in own done cycle goes behind the others
      do_reset();
      seq = '{2, 4, 1, 2};
      req = 4'b0010;
      @(negedge clk);
      req = 4'b0101;
      @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
      req = 4'b0010;
      for (int n = 0; n < 4; n++) begin
         wait_done(20, cyc, d);
         chk($sformatf("requeue%0d", n), {60'd0, d}, 64'(seq[n]));
      end

      // duplicate req while pending: exactly one done
      req = 4'b1000;
      @(negedge clk);
      req = 4'b1000;
      @(negedge clk);
      req = 4'b1000;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         req = '0;
         cnt += int'(done_a[3]) + int'(done_m[3]);
      end
      chk("dup_count", 64'(cnt), 64'd2);
      chk("dup_idle", {62'd0, idle_a, idle_m}, 64'd3);

      // reset in ST_WAIT aborts the job
      in0[3] = tri3(2, 3, 4);
      in1[3] = tri3(5, 6, 7);
      req = 4'b1000;
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);
      rstb = 1'b0;
      @(negedge clk);
      for (int j = 0; j < N; j++) begin
         expw_a[j] = '0;
         expw_m[j] = '0;
      end
      chk_words("abort");
      chk("abort_pend", {56'd0, pend_a, pend_m}, 64'd0);
      chk("abort_idle", {62'd0, idle_a, idle_m}, 64'd3);
      rstb = 1'b1;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         cnt += (done_a != 0 || done_m != 0) ? 1 : 0;
      end
      chk("abort_nodone", 64'(cnt), 64'd0);
      req = 4'b1000;
      wait_done(20, cyc, d);
      chk("abort_retry_lat", 64'(cyc), 64'd4);
      chk("abort_retry_add", 64'(gf_a[3]), 64'(tri3(7, 9, 11)));
      chk("abort_retry_mul", 64'(gf_m[3]), 64'(tri3(10, 18, 28)));

      // random traffic, bypass off then on
      do_reset();
      outst = '0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int ph = 0; ph < 2; ph++) begin
         mux_sel = ph[0];
         for (int c = 0; c < ((ph == 0) ? 8000 : 2000); c++) begin
            @(negedge clk);
            model_step();
            for (int i = 0; i < N; i++) begin
               req[i] = ($urandom_range(0, 5) == 0);
               if (req[i] && !outst[i]) begin
                  for (int k = 0; k < 3; k++) begin
                     in0[i][k] = rv();
                     in1[i][k] = rv();
                  end
               end
            end
         end
         cnt = 0;
         do begin
            @(negedge clk);
            model_step();
            req = '0;
            cnt++;
         end while ((outst != 0 || !idle_a || !idle_m) && cnt < 200);
         chk($sformatf("drain%0d", ph), {58'd0, outst, idle_a, idle_m}, 64'd3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
